// File: rtl/tcb_lite_arb.sv
// tcb_lite_arb: N-manager to 1-subordinate TCB-Lite arbiter and multiplexer.
//
// Managers are granted round-robin. A manager keeps the grant while the subordinate
// stalls it, and also while it holds an arbitration lock (req.lck). Request fields are
// muxed combinationally from the selected manager. Responses are routed back through
// a DLY-deep delay line of grant indices.
//
// Ports (man_* buses pack MPN fields, field i at [i*W +: W]):
//   clk, rst                     clock, synchronous active-high reset
//   man_vld / man_rdy            per-manager handshake
//   man_lck/ndn/wen/ctl/adr/siz/byt/wdt   per-manager request fields
//   man_rdt                      read data, broadcast to all managers
//   man_sts / man_err            response status / error, routed to one manager
//   sub_vld / sub_rdy            subordinate handshake
//   sub_lck/ndn/wen/ctl/adr/siz/byt/wdt   muxed request toward the subordinate
//   sub_rdt / sub_sts / sub_err  subordinate response
module tcb_lite_arb #(
    parameter int unsigned MPN = 2,
    parameter int unsigned DLY = 1,
    parameter int unsigned CTL = 1,
    parameter int unsigned ADR = 32,
    parameter int unsigned DAT = 32,
    parameter int unsigned STS = 1,
    localparam int unsigned BYT = DAT / 8,
    localparam int unsigned SIZ = $clog2($clog2(BYT) + 1)
) (
    input  logic               clk,
    input  logic               rst,
    // manager side
    input  logic [MPN-1:0]     man_vld,
    output logic [MPN-1:0]     man_rdy,
    input  logic [MPN-1:0]     man_lck,
    input  logic [MPN-1:0]     man_ndn,
    input  logic [MPN-1:0]     man_wen,
    input  logic [MPN*CTL-1:0] man_ctl,
    input  logic [MPN*ADR-1:0] man_adr,
    input  logic [MPN*SIZ-1:0] man_siz,
    input  logic [MPN*BYT-1:0] man_byt,
    input  logic [MPN*DAT-1:0] man_wdt,
    output logic [DAT-1:0]     man_rdt,
    output logic [MPN*STS-1:0] man_sts,
    output logic [MPN-1:0]     man_err,
    // subordinate side
    output logic               sub_vld,
    input  logic               sub_rdy,
    output logic               sub_lck,
    output logic               sub_ndn,
    output logic               sub_wen,
    output logic [CTL-1:0]     sub_ctl,
    output logic [ADR-1:0]     sub_adr,
    output logic [SIZ-1:0]     sub_siz,
    output logic [BYT-1:0]     sub_byt,
    output logic [DAT-1:0]     sub_wdt,
    input  logic [DAT-1:0]     sub_rdt,
    input  logic [STS-1:0]     sub_sts,
    input  logic               sub_err
);

    localparam int unsigned IW = $clog2(MPN);
    typedef logic [IW-1:0] idx_t;

    idx_t        ptr;   // round-robin start point
    idx_t        own;   // manager holding the grant (stall or lock)
    logic        lok;   // arbitration locked to own
    logic        hld;   // grant held across a subordinate stall
    idx_t        sel;
    int unsigned sel_i;
    logic        trn;
    logic        stall;

    // Grant selection: a held/locked owner wins outright, otherwise the first valid
    // manager at or after ptr. With nobody valid, sel parks on ptr.
    always_comb begin : p_sel
        logic        found;
        int unsigned pos;
        found = 1'b0;
        pos   = 0;
        sel   = ptr;
        if (lok || hld) begin
            sel = own;
        end else begin
            for (int unsigned k = 0; k < MPN; k++) begin
                pos = 32'(ptr) + k;
                if (pos >= MPN) begin
                    pos = pos - MPN;
                end
                if (!found && man_vld[idx_t'(pos)]) begin
                    sel   = idx_t'(pos);
                    found = 1'b1;
                end
            end
        end
    end

    assign sel_i = 32'(sel);

    assign sub_vld = ~rst & man_vld[sel];
    assign trn     = sub_vld & sub_rdy;
    assign stall   = sub_vld & ~sub_rdy;

    assign sub_lck = man_lck[sel];
    assign sub_ndn = man_ndn[sel];
    assign sub_wen = man_wen[sel];
    assign sub_ctl = man_ctl[sel_i*CTL +: CTL];
    assign sub_adr = man_adr[sel_i*ADR +: ADR];
    assign sub_siz = man_siz[sel_i*SIZ +: SIZ];
    assign sub_byt = man_byt[sel_i*BYT +: BYT];
    assign sub_wdt = man_wdt[sel_i*DAT +: DAT];

    always_comb begin
        man_rdy = '0;
        if (!rst && sub_rdy && man_vld[sel]) begin
            man_rdy[sel] = 1'b1;
        end
    end

    // Arbitration state. Any transfer advances ptr past the granted manager and
    // releases a stall hold; the lock follows the lck bit of each transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            own <= '0;
            lok <= 1'b0;
            hld <= 1'b0;
        end else begin
            if (trn) begin
                ptr <= (sel_i == MPN - 1) ? '0 : sel + 1'b1;
                hld <= 1'b0;
                if (sub_lck) begin
                    lok <= 1'b1;
                    own <= sel;
                end else begin
                    lok <= 1'b0;
                end
            end else if (stall && !lok) begin
                hld <= 1'b1;
                own <= sel;
            end
        end
    end

    // Response routing: which manager (if any) owns the response on this cycle.
    logic rsp_trn;
    idx_t rsp_idx;

    if (DLY == 0) begin : g_nodly
        assign rsp_trn = trn;
        assign rsp_idx = sel;
    end else begin : g_dly
        logic dly_trn [DLY];
        idx_t dly_idx [DLY];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DLY; k++) begin
                    dly_trn[k] <= 1'b0;
                    dly_idx[k] <= '0;
                end
            end else begin
                dly_trn[0] <= trn;
                dly_idx[0] <= sel;
                for (int k = 1; k < DLY; k++) begin
                    dly_trn[k] <= dly_trn[k-1];
                    dly_idx[k] <= dly_idx[k-1];
                end
            end
        end

        assign rsp_trn = dly_trn[DLY-1];
        assign rsp_idx = dly_idx[DLY-1];
    end

    assign man_rdt = sub_rdt;

    always_comb begin
        man_err = '0;
        man_sts = '0;
        if (!rst && rsp_trn) begin
            man_err[rsp_idx]                 = sub_err;
            man_sts[32'(rsp_idx)*STS +: STS] = sub_sts;
        end
    end

endmodule
